// File: rtl/periferico_tx.sv
// periferico_tx: peripheral-to-CPU transmitter.
// Local logic pushes words into a small FIFO. The FSM drains the FIFO one word
// at a time over a 4-phase send/ack handshake toward the CPU.
//
// Handshake: the block raises ptx_send with ptx_dados stable, then waits for
// ptx_ack=1. It drops ptx_send and waits for ptx_ack=0 before it loads the next
// word. An ack seen while idle is treated as stale and blocks the next load.
//
// Ports:
//   ptx_clock     clock, all state on the rising edge
//   ptx_reset     asynchronous active-low reset
//   ptx_wr_en     push strobe
//   ptx_wr_dados  word to push
//   ptx_full      FIFO holds FIFO_DEPTH words
//   ptx_empty     FIFO holds no words
//   ptx_count     FIFO occupancy
//   ptx_ovf       sticky flag: a push was dropped because the FIFO was full
//   ptx_send      request to the CPU: ptx_dados is valid
//   ptx_dados     word on the bus toward the CPU
//   ptx_ack       CPU acknowledge (same clock domain)
//   ptx_sent_cnt  completed transfers, wraps around
//   ptx_state     current FSM state (debug)
module periferico_tx #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2,
    parameter int CNT_W      = 8
) (
    input  logic              ptx_clock,
    input  logic              ptx_reset,
    input  logic              ptx_wr_en,
    input  logic [DATA_W-1:0] ptx_wr_dados,
    output logic              ptx_full,
    output logic              ptx_empty,
    output logic [ADDR_W:0]   ptx_count,
    output logic              ptx_ovf,
    output logic              ptx_send,
    output logic [DATA_W-1:0] ptx_dados,
    input  logic              ptx_ack,
    output logic [CNT_W-1:0]  ptx_sent_cnt,
    output logic [1:0]        ptx_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                ovf_q;
    logic                send_q;
    logic [DATA_W-1:0]   dados_q;
    logic [CNT_W-1:0]    sent_cnt_q;

    logic load;      // pop the FIFO head onto the bus this cycle
    logic ack_done;  // transfer completes this cycle
    logic push_ok;

    assign ptx_full     = (count_q == DEPTH_C);
    assign ptx_empty    = (count_q == '0);
    assign ptx_count    = count_q;
    assign ptx_ovf      = ovf_q;
    assign ptx_send     = send_q;
    assign ptx_dados    = dados_q;
    assign ptx_sent_cnt = sent_cnt_q;
    assign ptx_state    = state_q;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; the freed slot is the one being written.
    assign push_ok = ptx_wr_en && (!ptx_full || load);

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        ack_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ptx_empty && !ptx_ack) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ptx_ack) begin
                    ack_done = 1'b1;
                    state_d  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ptx_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ptx_clock or negedge ptx_reset) begin
        if (!ptx_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            send_q     <= 1'b0;
            dados_q    <= '0;
            sent_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= (state_d == SEND);
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dados_q  <= mem[rd_ptr_q];
            end
            case ({push_ok, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ptx_wr_en && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (ack_done) begin
                sent_cnt_q <= sent_cnt_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge ptx_clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= ptx_wr_dados;
        end
    end

endmodule

// File: tb/tb_periferico_tx.sv
// Self-checking bench for periferico_tx. Words accepted into the FIFO are queued
// as expected bus values and popped when the DUT loads a word onto ptx_dados.
module tb_periferico_tx;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int CW = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_dados = '0;
    logic          man_ack  = 1'b0;
    logic          auto_ack = 1'b0;
    logic          ack_reg  = 1'b0;
    logic          ptx_ack;

    logic          ptx_full, ptx_empty, ptx_ovf, ptx_send;
    logic [AW:0]   ptx_count;
    logic [DW-1:0] ptx_dados;
    logic [CW-1:0] ptx_sent_cnt;
    logic [1:0]    ptx_state;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_sent    = '0;

    periferico_tx #(.DATA_W(DW), .FIFO_DEPTH(4), .ADDR_W(AW), .CNT_W(CW)) dut (
        .ptx_clock    (clk),
        .ptx_reset    (rst_n),
        .ptx_wr_en    (wr_en),
        .ptx_wr_dados (wr_dados),
        .ptx_full     (ptx_full),
        .ptx_empty    (ptx_empty),
        .ptx_count    (ptx_count),
        .ptx_ovf      (ptx_ovf),
        .ptx_send     (ptx_send),
        .ptx_dados    (ptx_dados),
        .ptx_ack      (ptx_ack),
        .ptx_sent_cnt (ptx_sent_cnt),
        .ptx_state    (ptx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // CPU-side responder model: registers ack = send one cycle later.
    always @(posedge clk) ack_reg <= auto_ack ? ptx_send : 1'b0;
    assign ptx_ack = auto_ack ? ack_reg : man_ack;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit accept);
        wr_en    = 1'b1;
        wr_dados = d;
        tick();
        wr_en    = 1'b0;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        man_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_sent = '0;
    endtask

    // Scoreboard: a load must raise send and show the oldest accepted word.
    task automatic sb_check_load(input string name);
        logic [DW-1:0] exp_w;
        vectors++;
        if (ptx_send !== 1'b1) begin
            miscompares++;
            $display("FAIL %s send: got %0b expected 1", name, ptx_send);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s dados: got %0h expected nothing queued", name, ptx_dados);
        end else begin
            exp_w = exp_q.pop_front();
            if (ptx_dados !== exp_w) begin
                miscompares++;
                $display("FAIL %s dados: got %0h expected %0h", name, ptx_dados, exp_w);
            end
        end
    endtask

    // Complete the current SEND with a manual ack pulse, ending in IDLE.
    task automatic handshake_one(input string name);
        man_ack = 1'b1;
        tick();
        exp_sent = exp_sent + 1'b1;
        vectors++;
        if (ptx_send !== 1'b0 || ptx_sent_cnt !== exp_sent) begin
            miscompares++;
            $display("FAIL %s ack: send=%0b cnt=%0d expected send=0 cnt=%0d",
                     name, ptx_send, ptx_sent_cnt, exp_sent);
        end
        man_ack = 1'b0;
        tick();
        vectors++;
        if (ptx_state !== 2'd0) begin
            miscompares++;
            $display("FAIL %s release: state=%0d expected 0", name, ptx_state);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_dados = DW'($urandom_range(0, 15));
            man_ack  = 1'($urandom_range(0, 1));
            tick();
        end
        vectors++;
        if (ptx_send !== 1'b0 || ptx_dados !== '0 || ptx_sent_cnt !== '0 ||
            ptx_count !== '0 || ptx_ovf !== 1'b0 || ptx_full !== 1'b0 ||
            ptx_empty !== 1'b1 || ptx_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_values: send=%0b dados=%0h cnt=%0d count=%0d ovf=%0b full=%0b empty=%0b state=%0d expected 0,0,0,0,0,0,1,0",
                     ptx_send, ptx_dados, ptx_sent_cnt, ptx_count, ptx_ovf, ptx_full, ptx_empty, ptx_state);
        end
        wr_en   = 1'b0;
        man_ack = 1'b0;
        rst_n   = 1'b1;
        exp_q.delete();
        exp_sent = '0;
        push_word(4'h3, 1'b1);
        vectors++;
        if (ptx_count !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_first_push count: got %0d expected 1", ptx_count);
        end
        tick();
        sb_check_load("reset_first_load");
        handshake_one("reset_first_hs");
    endtask

    task automatic test_single();
        auto_ack = 1'b1;
        push_word(4'hA, 1'b1);                 // edge N
        tick();                                 // N+1: load
        sb_check_load("single_load");
        tick();                                 // N+2: responder raises ack
        tick();                                 // N+3: ack seen
        exp_sent = exp_sent + 1'b1;
        vectors++;
        if (ptx_send !== 1'b0 || ptx_sent_cnt !== exp_sent) begin
            miscompares++;
            $display("FAIL single_ack: send=%0b cnt=%0d expected send=0 cnt=%0d",
                     ptx_send, ptx_sent_cnt, exp_sent);
        end
        tick();                                 // N+4: responder drops ack
        tick();                                 // N+5: low ack sampled
        vectors++;
        if (ptx_state !== 2'd0 || ptx_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_idle: state=%0d empty=%0b expected 0,1", ptx_state, ptx_empty);
        end
        auto_ack = 1'b0;
        tick();
    endtask

    task automatic test_stale_ack();
        man_ack = 1'b1;
        push_word(4'h5, 1'b1);
        tick();
        tick();
        vectors++;
        if (ptx_send !== 1'b0 || ptx_state !== 2'd0 || ptx_count !== 3'd1) begin
            miscompares++;
            $display("FAIL stale_ack: send=%0b state=%0d count=%0d expected 0,0,1",
                     ptx_send, ptx_state, ptx_count);
        end
        man_ack = 1'b0;
        tick();
        sb_check_load("stale_release_load");
        handshake_one("stale_hs");
    endtask

    task automatic test_simultaneous();
        man_ack = 1'b1;                         // hold off the load
        push_word(4'h9, 1'b1);
        man_ack = 1'b0;
        push_word(4'h7, 1'b1);                  // same edge as load of 9
        vectors++;
        if (ptx_count !== 3'd1) begin
            miscompares++;
            $display("FAIL simul_count: got %0d expected 1", ptx_count);
        end
        sb_check_load("simul_load");
        handshake_one("simul_hs0");
        tick();
        sb_check_load("simul_second");
        handshake_one("simul_hs1");
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 5; i++) push_word(DW'(i), 1'b1);
        vectors++;
        if (ptx_full !== 1'b1 || ptx_count !== 3'd4 || ptx_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL fill: full=%0b count=%0d ovf=%0b expected 1,4,0",
                     ptx_full, ptx_count, ptx_ovf);
        end
        sb_check_load("fill_first");
        push_word(4'h6, 1'b0);
        vectors++;
        if (ptx_ovf !== 1'b1 || ptx_count !== 3'd4 || ptx_send !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: ovf=%0b count=%0d send=%0b expected 1,4,1",
                     ptx_ovf, ptx_count, ptx_send);
        end
        for (int k = 0; k < 4; k++) begin
            handshake_one("fill_hs");
            tick();
            sb_check_load("fill_drain");
        end
        handshake_one("fill_last_hs");
        vectors++;
        if (ptx_empty !== 1'b1 || ptx_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_end: empty=%0b ovf=%0b expected 1,1", ptx_empty, ptx_ovf);
        end
        do_reset();
        // Full FIFO: push on the same edge as a pop is accepted, no overflow.
        man_ack = 1'b1;
        for (int i = 0; i < 4; i++) push_word(DW'(8 + i), 1'b1);
        man_ack = 1'b0;
        push_word(4'hE, 1'b1);
        vectors++;
        if (ptx_ovf !== 1'b0 || ptx_count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_push_pop: ovf=%0b count=%0d expected 0,4", ptx_ovf, ptx_count);
        end
        sb_check_load("full_push_pop_load");
        for (int k = 0; k < 4; k++) begin
            handshake_one("fpp_hs");
            tick();
            sb_check_load("fpp_drain");
        end
        handshake_one("fpp_last_hs");
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 256; i++) begin
            push_word(DW'($urandom_range(0, 15)), 1'b1);
            tick();
            sb_check_load("wrap_load");
            handshake_one("wrap_hs");
        end
    endtask

    task automatic test_reset_mid();
        push_word(4'hC, 1'b1);
        tick();
        sb_check_load("mid_load");
        #3;
        rst_n = 1'b0;                           // between clock edges
        #1;
        vectors++;
        if (ptx_send !== 1'b0 || ptx_empty !== 1'b1 || ptx_count !== '0 ||
            ptx_state !== 2'd0 || ptx_sent_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: send=%0b empty=%0b count=%0d state=%0d cnt=%0d expected 0,1,0,0,0",
                     ptx_send, ptx_empty, ptx_count, ptx_state, ptx_sent_cnt);
        end
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_sent = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_stale_ack();
        test_simultaneous();
        test_fill_overflow();
        test_counter_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
